// File: rtl/dm_access_ctrl.sv
// Data-memory access sequencer: round-robin arbitration between the MEM stage
// and an external loader, with a fixed multi-cycle memory latency and MEM stall.
module dm_access_ctrl #(
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter int unsigned DATA_SIZE    = 32,
  parameter int unsigned DM_LATENCY   = 2,
  parameter logic [5:0]  OP_LW        = 6'b100011,
  parameter logic [5:0]  OP_SW        = 6'b101011
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  input  logic [5:0]              mem_op,
  input  logic [ADDRESS_SIZE-1:0] mem_addr,
  input  logic [DATA_SIZE-1:0]    mem_wdata,
  output logic [DATA_SIZE-1:0]    mem_rdata,
  output logic                    mem_done,
  output logic                    mem_stall_c,
  input  logic                    ext_req,
  input  logic                    ext_we,
  input  logic [ADDRESS_SIZE-1:0] ext_addr,
  input  logic [DATA_SIZE-1:0]    ext_wdata,
  output logic                    ext_gnt,
  output logic [DATA_SIZE-1:0]    ext_rdata,
  output logic                    ext_done,
  input  logic [DATA_SIZE-1:0]    dm_read_data,
  output logic                    dm_write_enable,
  output logic [ADDRESS_SIZE-1:0] dm_write_address,
  output logic [DATA_SIZE-1:0]    dm_write_data,
  output logic [ADDRESS_SIZE-1:0] dm_read_address
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_MEM, OWN_EXT} owner_t;

  localparam logic [3:0] CNT_INIT = 4'(DM_LATENCY - 1);

  state_t     state;
  owner_t     owner;
  owner_t     last_owner;
  logic [3:0] cnt;
  logic       acc_write;

  logic                    mem_ls;
  logic                    mem_elig;
  logic                    ext_elig;
  logic                    grant_mem;
  logic                    grant_ext;
  logic [ADDRESS_SIZE-1:0] req_addr;
  logic [DATA_SIZE-1:0]    req_wdata;
  logic                    req_we;

  assign mem_ls      = mem_req_valid & ((mem_op == OP_LW) | (mem_op == OP_SW));
  assign mem_elig    = mem_ls & ~mem_done;
  assign ext_elig    = ext_req & ~ext_done;
  assign mem_stall_c = mem_ls & ~mem_done;

  // On a tie MEM wins only if EXT owned the previous access.
  always_comb begin
    grant_mem = mem_elig & (~ext_elig | (last_owner == OWN_EXT));
    grant_ext = ext_elig & ~grant_mem;
    req_addr  = grant_mem ? mem_addr  : ext_addr;
    req_wdata = grant_mem ? mem_wdata : ext_wdata;
    req_we    = grant_mem ? (mem_op == OP_SW) : ext_we;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      owner            <= OWN_MEM;
      last_owner       <= OWN_EXT;
      cnt              <= '0;
      acc_write        <= 1'b0;
      mem_rdata        <= '0;
      mem_done         <= 1'b0;
      ext_gnt          <= 1'b0;
      ext_rdata        <= '0;
      ext_done         <= 1'b0;
      dm_write_enable  <= 1'b0;
      dm_write_address <= '0;
      dm_write_data    <= '0;
      dm_read_address  <= '0;
    end else begin
      mem_done        <= 1'b0;
      ext_done        <= 1'b0;
      ext_gnt         <= 1'b0;
      dm_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_mem | grant_ext) begin
            state            <= BUSY;
            cnt              <= CNT_INIT;
            owner            <= grant_mem ? OWN_MEM : OWN_EXT;
            last_owner       <= grant_mem ? OWN_MEM : OWN_EXT;
            dm_read_address  <= req_addr;
            dm_write_address <= req_addr;
            dm_write_data    <= req_wdata;
            dm_write_enable  <= req_we;
            acc_write        <= req_we;
            ext_gnt          <= grant_ext;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= IDLE;
            if (owner == OWN_MEM) begin
              mem_done <= 1'b1;
              if (!acc_write) mem_rdata <= dm_read_data;
            end else begin
              ext_done <= 1'b1;
              if (!acc_write) ext_rdata <= dm_read_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
